// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU arbiter: opcodes, FSM states, default width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone valid always wins,
// a tie goes to the requester named by the pointer.
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the valid pair and the priority pointer
  always_comb begin
    grant_o = 2'b00;
    if (valid_i == 2'b11) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one registered ALU between two requesters with round-robin arbitration.
// Flow: IDLE (accept) -> EXEC (ALU_LAT+1 cycles) -> RESP (wait for consumer) -> IDLE.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_z
);

  // Counter is loaded with ALU_LAT, so EXEC spans ALU_LAT+1 cycles.
  localparam int CNT_W = $clog2(ALU_LAT + 1) + 1;

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic             rsp0_zero_q, rsp0_zero_d;
  logic             rsp1_zero_q, rsp1_zero_d;
  logic [1:0]       grant_s;
  logic             rsp_done_s;

  rr_pick2 u_pick (
    .valid_i (({req1_valid, req0_valid})),
    .ptr_i   (ptr_q),
    .grant_o (grant_s)
  );

  // Ready is offered only in IDLE, and only to the picked requester
  assign req0_ready = (state_q == IDLE) && grant_s[0];
  assign req1_ready = (state_q == IDLE) && grant_s[1];

  assign rsp_done_s = gnt_id_q ? (rsp1_valid_q && rsp1_ready) : (rsp0_valid_q && rsp0_ready);

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_zero   = rsp1_zero_q;

  // Next-state and next-register computation for the arbitration FSM
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_id_d      = gnt_id_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    rsp1_zero_d   = rsp1_zero_q;
    case (state_q)
      IDLE: begin
        if (grant_s != 2'b00) begin
          gnt_id_d  = grant_s[1];
          alu_a_d   = grant_s[1] ? req1_a : req0_a;
          alu_b_d   = grant_s[1] ? req1_b : req0_b;
          alu_sel_d = grant_s[1] ? req1_sel : req0_sel;
          cnt_d     = CNT_W'(ALU_LAT);
          state_d   = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          if (gnt_id_q) begin
            rsp1_result_d = alu_r;
            rsp1_zero_d   = alu_z;
            rsp1_valid_d  = 1'b1;
          end else begin
            rsp0_result_d = alu_r;
            rsp0_zero_d   = alu_z;
            rsp0_valid_d  = 1'b1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_done_s) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          ptr_d        = ~gnt_id_q;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      ptr_q         <= 1'b0;
      gnt_id_q      <= 1'b0;
      cnt_q         <= {CNT_W{1'b0}};
      alu_a_q       <= {WIDTH{1'b0}};
      alu_b_q       <= {WIDTH{1'b0}};
      alu_sel_q     <= 3'b000;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= {WIDTH{1'b0}};
      rsp1_result_q <= {WIDTH{1'b0}};
      rsp0_zero_q   <= 1'b0;
      rsp1_zero_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_id_q      <= gnt_id_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_zero_q   <= rsp1_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with an ALU_LAT=1 and an ALU_LAT=3 instance.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---- main DUT (ALU_LAT = 1) ----
  logic        r0v = 1'b0, r1v = 1'b0;
  logic [31:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
  logic [2:0]  r0s = '0, r1s = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_sel;
  logic        alu_z;

  // ---- latency DUT (ALU_LAT = 3) ----
  logic        l_r0v = 1'b0;
  logic [31:0] l_r0a = '0, l_r0b = '0;
  logic [2:0]  l_r0s = '0;
  logic        l_r1v = 1'b0;
  logic [31:0] l_r1a = '0, l_r1b = '0;
  logic [2:0]  l_r1s = '0;
  logic        l_q0r, l_q1r, l_p0v, l_p1v, l_p0z, l_p1z;
  logic [31:0] l_p0r, l_p1r, l_alu_a, l_alu_b, l_alu_r;
  logic [2:0]  l_alu_sel;
  logic        l_alu_z;

  int n_cmp = 0;
  int n_err = 0;
  bit seen_rsp1 = 1'b0;

  alu_rr_arbiter #(.WIDTH(32), .ALU_LAT(1)) u_dut (
    .CLK(clk), .RST(rst),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_a(r0a), .req0_b(r0b), .req0_sel(r0s),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_a(r1a), .req1_b(r1b), .req1_sel(r1s),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_r(alu_r), .alu_z(alu_z)
  );

  alu_rr_arbiter #(.WIDTH(32), .ALU_LAT(3)) u_dut3 (
    .CLK(clk), .RST(rst),
    .req0_valid(l_r0v), .req0_ready(l_q0r), .req0_a(l_r0a), .req0_b(l_r0b), .req0_sel(l_r0s),
    .req1_valid(l_r1v), .req1_ready(l_q1r), .req1_a(l_r1a), .req1_b(l_r1b), .req1_sel(l_r1s),
    .rsp0_valid(l_p0v), .rsp0_ready(1'b1), .rsp0_result(l_p0r), .rsp0_zero(l_p0z),
    .rsp1_valid(l_p1v), .rsp1_ready(1'b1), .rsp1_result(l_p1r), .rsp1_zero(l_p1z),
    .alu_a(l_alu_a), .alu_b(l_alu_b), .alu_sel(l_alu_sel), .alu_r(l_alu_r), .alu_z(l_alu_z)
  );

  // External ALU behaviour: {zero, result}
  function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    logic [31:0] r;
    case (sel)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_MUL:  r = a * b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {31'd0, (a < b)};
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  logic [32:0] p1 = '0;
  logic [32:0] p3 [3] = '{33'd0, 33'd0, 33'd0};

  // One-stage ALU for the main DUT
  always @(posedge clk) p1 <= alu_fn(alu_a, alu_b, alu_sel);
  assign alu_r = p1[31:0];
  assign alu_z = p1[32];

  // Three-stage ALU for the latency DUT
  always @(posedge clk) begin
    p3[0] <= alu_fn(l_alu_a, l_alu_b, l_alu_sel);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign l_alu_r = p3[2][31:0];
  assign l_alu_z = p3[2][32];

  // Sticky record of any response on channel 1
  always @(negedge clk) if (rsp1_valid === 1'b1) seen_rsp1 = 1'b1;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present a request, wait (bounded) for ready, take the accept edge.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel, input string tag);
    int waited = 0;
    if (id == 1) begin r1v = 1'b1; r1a = a; r1b = b; r1s = sel; end
    else begin r0v = 1'b1; r0a = a; r0b = b; r0s = sel; end
    #1;
    while (!(id == 1 ? req1_ready : req0_ready) && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    check_eq({tag, " accept"}, (id == 1 ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    if (id == 1) r1v = 1'b0; else r0v = 1'b0;
  endtask

  // Called just after the accept edge: wait for rsp_valid, check latency and payload.
  task automatic await_rsp(input int id, input logic [31:0] exp_res, input logic exp_z,
                           input int exp_lat, input string tag);
    int n = 0;
    while (!(id == 1 ? rsp1_valid : rsp0_valid) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, " latency"}, n, exp_lat);
    check_eq({tag, " result"}, (id == 1 ? rsp1_result : rsp0_result), exp_res);
    check_eq({tag, " zero"}, (id == 1 ? rsp1_zero : rsp0_zero), exp_z);
  endtask

  logic [31:0] sweep_exp [8] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

  initial begin
    int got;
    int n;

    // ---- reset state ----
    do_reset();
    check_eq("rst rsp0_valid", rsp0_valid, 32'd0);
    check_eq("rst rsp1_valid", rsp1_valid, 32'd0);
    check_eq("rst alu_a", alu_a, 32'd0);
    check_eq("rst alu_sel", alu_sel, 32'd0);
    check_eq("rst rsp0_result", rsp0_result, 32'd0);
    check_eq("rst req0_ready", req0_ready, 32'd0);
    seen_rsp1 = 1'b0;

    // ---- single request ----
    issue(0, 32'd5, 32'd7, 3'b000, "single");
    check_eq("single ready one cycle", req0_ready, 32'd0);
    check_eq("single alu_a", alu_a, 32'd5);
    await_rsp(0, 32'd12, 1'b0, 2, "single");
    @(posedge clk); #1;
    check_eq("single rsp0 cleared", rsp0_valid, 32'd0);
    check_eq("single no rsp1", seen_rsp1, 32'd0);

    // ---- contention and alternation ----
    do_reset();
    r0a = 32'd9; r0b = 32'd9; r0s = 3'b100;
    r1a = 32'd3; r1b = 32'd4; r1s = 3'b011;
    r0v = 1'b1; r1v = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(posedge clk); #1; n++;
      end
      got = req1_ready ? 1 : 0;
      check_eq($sformatf("contend grant %0d", k), got, k % 2);
      check_eq($sformatf("contend exclusive %0d", k), (req0_ready & req1_ready), 32'd0);
      @(posedge clk); #1;
      if (k == 3) begin r0v = 1'b0; r1v = 1'b0; end
      await_rsp(got, (got == 1) ? 32'd12 : 32'd0, (got == 1) ? 1'b0 : 1'b1, 2,
                $sformatf("contend op%0d", k));
    end
    @(posedge clk); #1;

    // ---- backpressure on channel 1 ----
    rsp1_ready = 1'b0;
    issue(1, 32'd2, 32'd3, 3'b101, "bp");
    await_rsp(1, 32'd1, 1'b0, 2, "bp");
    r0v = 1'b1; r0a = 32'd1; r0b = 32'd2; r0s = 3'b001;
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("bp hold valid %0d", c), rsp1_valid, 32'd1);
      check_eq($sformatf("bp hold result %0d", c), rsp1_result, 32'd1);
      check_eq($sformatf("bp req0 blocked %0d", c), req0_ready, 32'd0);
      check_eq($sformatf("bp rsp0 idle %0d", c), rsp0_valid, 32'd0);
      @(posedge clk); #1;
    end
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp rsp1 cleared", rsp1_valid, 32'd0);
    check_eq("bp req0 now ready", req0_ready, 32'd1);
    issue(0, 32'd1, 32'd2, 3'b001, "bp follow");
    await_rsp(0, 32'd0, 1'b1, 2, "bp follow");

    // ---- opcode sweep ----
    for (int s = 0; s < 8; s++) begin
      issue(0, 32'hFFFF_FFFF, 32'd1, 3'(s), $sformatf("sweep sel%0d", s));
      await_rsp(0, sweep_exp[s], (sweep_exp[s] == 32'd0), 2, $sformatf("sweep sel%0d", s));
    end
    @(posedge clk); #1;

    // ---- reset in the second EXEC cycle (pointer is 1 here) ----
    issue(0, 32'd4, 32'd4, 3'b000, "midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("midrst rsp0_valid", rsp0_valid, 32'd0);
    check_eq("midrst rsp1_valid", rsp1_valid, 32'd0);
    check_eq("midrst alu_a", alu_a, 32'd0);
    check_eq("midrst alu_b", alu_b, 32'd0);
    check_eq("midrst alu_sel", alu_sel, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("midrst no response", rsp0_valid, 32'd0);
    r0a = 32'd6; r0b = 32'd1; r0s = 3'b100;
    r1a = 32'd7; r1b = 32'd8; r1s = 3'b000;
    r0v = 1'b1; r1v = 1'b1;
    #1;
    check_eq("midrst ptr0 req0", req0_ready, 32'd1);
    check_eq("midrst ptr0 req1", req1_ready, 32'd0);
    @(posedge clk); #1;
    r0v = 1'b0;
    await_rsp(0, 32'd5, 1'b0, 2, "midrst req0");
    issue(1, 32'd7, 32'd8, 3'b000, "midrst req1");
    await_rsp(1, 32'd15, 1'b0, 2, "midrst req1");
    @(posedge clk); #1;

    // ---- ALU_LAT = 3 instance ----
    l_r0v = 1'b1; l_r0a = 32'd10; l_r0b = 32'd3; l_r0s = 3'b100;
    #1;
    check_eq("lat3 accept", l_q0r, 32'd1);
    @(posedge clk); #1;
    l_r0v = 1'b0;
    n = 0;
    while (!l_p0v && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq("lat3 latency", n, 32'd4);
    check_eq("lat3 result", l_p0r, 32'd7);
    check_eq("lat3 zero", l_p0z, 32'd0);
    @(posedge clk); #1;
    check_eq("lat3 cleared", l_p0v, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
